// File: rtl/booth_mult_pkg.sv
// Shared types and the Booth recoding helper for the radix-2 valid/ready multiplier.
// The controller and the datapath both import this package.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // Radix-2 recoding of the pair {Q[0], Q(-1)}.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_dp.sv
// Booth datapath: accumulator A, multiplier Q, Q(-1), multiplicand M, step counter and product register.
// One add/subtract plus arithmetic right shift per step; the product is captured on the final step.
module booth_mult_dp
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_is_signed,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_last_step,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH:0]     r_a;
    logic [WIDTH:0]     r_q;
    logic [WIDTH:0]     r_m;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_q_ext;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_a_next;
    logic [WIDTH:0]     w_q_next;
    booth_op_t          w_op;

    // The extra top bit makes unsigned operands look like positive signed ones.
    assign w_m_ext = {i_is_signed & i_multiplicand[WIDTH-1], i_multiplicand};
    assign w_q_ext = {i_is_signed & i_multiplier[WIDTH-1], i_multiplier};
    assign w_op    = booth_decode({r_q[0], r_qm1});

    // Conditional add/subtract of M into the accumulator.
    always_comb begin
        w_sum = r_a;
        case (w_op)
            ADD:     w_sum = r_a + r_m;
            SUB:     w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_next    = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_next    = {w_sum[0], r_q[WIDTH:1]};
    assign o_last_step = (r_cnt == CNT_ONE);
    assign o_product   = r_product;

    // Operand load and per-cycle Booth step of {A, Q, Q(-1)}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= '0;
            r_q   <= w_q_ext;
            r_m   <= w_m_ext;
            r_qm1 <= 1'b0;
            r_cnt <= CNT_INIT;
        end else if (i_step) begin
            r_a   <= w_a_next;
            r_q   <= w_q_next;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Product capture on the last step; held untouched until the next final step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_product <= '0;
        end else if (i_step && o_last_step) begin
            r_product <= {w_a_next[WIDTH-2:0], w_q_next};
        end
    end

endmodule

// File: rtl/booth_mult_vr.sv
// Iterative radix-2 Booth multiplier with valid/ready on both sides and a per-transaction signed mode.
// Holds the IDLE/BUSY/DONE controller and handshake logic around booth_mult_dp.
module booth_mult_vr
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 dest_valid,
    input  logic                 dest_ready,
    output logic [2*WIDTH-1:0]   product
);

    state_t r_state;
    state_t w_state_next;
    logic   w_load;
    logic   w_step;
    logic   w_last_step;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake; src_ready depends on state and dest_ready only, never on src_valid.
    always_comb begin
        w_state_next = r_state;
        src_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    w_state_next = BUSY;
                end else begin
                    w_state_next = IDLE;
                end
            end
            BUSY: begin
                if (w_last_step) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = BUSY;
                end
            end
            DONE: begin
                src_ready = dest_ready;
                if (dest_ready && src_valid) begin
                    w_state_next = BUSY;
                end else if (dest_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_load     = src_valid & src_ready;
    assign w_step     = (r_state == BUSY);
    assign dest_valid = (r_state == DONE);

    booth_mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_load),
        .i_step         (w_step),
        .i_is_signed    (is_signed),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .o_last_step    (w_last_step),
        .o_product      (product)
    );

endmodule

// File: tb/tb_booth_mult_vr.sv
// Scoreboard bench for booth_mult_vr (WIDTH=8): the driver queues hand-computed products on accept,
// an independent monitor pops and compares on every consume and checks latency and hold behaviour.
module tb_booth_mult_vr;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           src_valid = 1'b0;
    logic           src_ready;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           is_signed = 1'b0;
    logic           dest_valid;
    logic           dest_ready = 1'b1;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_push = 0;
    int n_cons = 0;
    int b2b_cons = 0;
    int last_cons = 0;
    bit b2b = 1'b0;

    logic [15:0] q_exp[$];
    int          q_tacc[$];

    logic        prev_dv = 1'b0;
    logic        prev_dr = 1'b0;
    logic [15:0] prev_prod = '0;

    booth_mult_vr #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .is_signed    (is_signed),
        .dest_valid   (dest_valid),
        .dest_ready   (dest_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: latency on dest_valid rise, product on consume, hold while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            prev_dv = 1'b0;
            prev_dr = 1'b0;
        end else begin
            if (prev_dv && !prev_dr) begin
                check("hold_valid", 32'(dest_valid), 32'd1);
                check("hold_product", 32'(product), 32'(prev_prod));
            end
            if (dest_valid && !prev_dv) begin
                if (q_tacc.size() == 0) flag("unexpected_valid");
                else check("latency", 32'(cyc - q_tacc.pop_front()), 32'd10);
            end
            if (dest_valid && dest_ready) begin
                if (q_exp.size() == 0) flag("unexpected_result");
                else check("product", 32'(product), 32'(q_exp.pop_front()));
                n_cons++;
                if (b2b) begin
                    if (b2b_cons > 0) check("b2b_interval", 32'(cyc - last_cons), 32'd10);
                    if (b2b_cons < 3) check("b2b_overlap", 32'(src_valid && src_ready), 32'd1);
                    b2b_cons++;
                end
                last_cons = cyc;
            end
            prev_dv   = dest_valid;
            prev_dr   = dest_ready;
            prev_prod = product;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input bit keep);
        bit ok;
        ok = 1'b0;
        src_valid    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (src_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            flag("accept_timeout");
        end else begin
            q_exp.push_back(exp);
            q_tacc.push_back(cyc);
            n_push++;
        end
        @(posedge clk);
        #1;
        if (!keep) src_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q_exp.size() == 0 && !dest_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_src_ready", 32'(src_ready), 32'd1);
        check("reset_dest_valid", 32'(dest_valid), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        send(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0); wait_idle();
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0); wait_idle();
        send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0); wait_idle();
        send(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0); wait_idle();
        send(8'h80, 8'h80, 1'b0, 16'h4000, 1'b0); wait_idle();
        send(8'h7F, 8'h81, 1'b1, 16'hC0FF, 1'b0); wait_idle();
        send(8'h7F, 8'h81, 1'b0, 16'h3FFF, 1'b0); wait_idle();
        send(8'h5A, 8'h00, 1'b1, 16'h0000, 1'b0); wait_idle();
        send(8'h00, 8'hC3, 1'b0, 16'h0000, 1'b0); wait_idle();

        // Backpressure: result must sit untouched for 20 cycles, then go exactly once.
        dest_ready = 1'b0;
        send(8'h0C, 8'h0D, 1'b0, 16'h009C, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dest_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag("bp_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", 32'(dest_valid), 32'd1);
            check("bp_src_ready", 32'(src_ready), 32'd0);
            check("bp_product", 32'(product), 32'h009C);
        end
        n0 = n_cons;
        @(posedge clk);
        #1 dest_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_single_valid", 32'(dest_valid), 32'd0);
        check("bp_single_count", 32'(n_cons), 32'(n0 + 1));
        wait_idle();

        // Back-to-back with src_valid and dest_ready held high.
        b2b = 1'b1;
        b2b_cons = 0;
        send(8'h03, 8'h04, 1'b0, 16'h000C, 1'b1);
        send(8'hFE, 8'h03, 1'b1, 16'hFFFA, 1'b1);
        send(8'h10, 8'h10, 1'b0, 16'h0100, 1'b1);
        send(8'h81, 8'h02, 1'b1, 16'hFF02, 1'b0);
        wait_idle();
        check("b2b_count", 32'(b2b_cons), 32'd4);
        b2b = 1'b0;

        // Reset in the middle of a computation; the partial result must never appear.
        src_valid    = 1'b1;
        multiplicand = 8'h12;
        multiplier   = 8'h34;
        is_signed    = 1'b0;
        @(negedge clk);
        check("pre_rst_ready", 32'(src_ready), 32'd1);
        @(posedge clk);
        #1 src_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_src_ready", 32'(src_ready), 32'd1);
        check("rst_dest_valid", 32'(dest_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(dest_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'h07, 8'h06, 1'b0, 16'h002A, 1'b0);
        wait_idle();

        check("all_consumed", 32'(n_cons), 32'(n_push));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
